// File: rtl/cache_dados_pkg.sv
// -----------------------------------------------------------------------------
// cache_dados_pkg
// Shared definitions for the direct-mapped data cache: FSM state encodings
// and the default widths used by cache_dados and cache_array.
// -----------------------------------------------------------------------------
package cache_dados_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_MISS = 2'd1;
    localparam state_t WR_MEM  = 2'd2;
    localparam state_t WR_DONE = 2'd3;

endpackage

// File: rtl/cache_array.sv
// -----------------------------------------------------------------------------
// cache_array
// Tag, data and valid storage for a one-word-per-line direct-mapped cache.
// Ports:
//   clk, rst        clock; asynchronous active-low clear of all valid bits
//   rd_index        combinational read port index
//   rd_valid/tag/data  contents of the addressed line
//   we, wr_index, wr_tag, wr_data  synchronous write port (sets valid)
// -----------------------------------------------------------------------------
module cache_array
    import cache_dados_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_dados.sv
// -----------------------------------------------------------------------------
// cache_dados
// Direct-mapped, write-through, no-write-allocate data cache between the
// multicycle MIPS core and main data memory, with saturating hit/miss counters.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   address, data       word address / store data from the core
//   r_en, w_en          active-low load / store requests (store wins)
//   stall               high while the current request is incomplete
//   saida_cache         load result (valid when r_en=0 and stall=0)
//   mem_addr, mem_wdata memory-side address / write data
//   mem_rd, mem_wr      memory strobes, held until mem_ack
//   mem_rdata, mem_ack  memory read data and one-cycle completion pulse
//   hit_count, miss_count  saturating load hit / miss counters
// -----------------------------------------------------------------------------
module cache_dados
    import cache_dados_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              r_en,
    input  logic              w_en,
    output logic              stall,
    output logic [DATA_W-1:0] saida_cache,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t             state;
    logic               fill_p1;     // set for the IDLE cycle right after a fill
    logic [ADDR_W-1:0]  rd_addr;
    logic [INDEX_W-1:0] rd_index;
    logic [TAG_W-1:0]   rd_tag_req;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               hit;
    logic               arr_we;
    logic [INDEX_W-1:0] wr_index;
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;
    logic               hit_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // In IDLE the lookup follows the core; while a transaction is in flight it
    // follows the latched memory address so the core is never re-sampled.
    assign rd_addr    = (state == IDLE) ? address : mem_addr;
    assign rd_index   = rd_addr[INDEX_W-1:0];
    assign rd_tag_req = rd_addr[ADDR_W-1:INDEX_W];
    assign hit        = line_valid && (line_tag == rd_tag_req);

    assign wr_index = mem_addr[INDEX_W-1:0];
    assign wr_tag   = mem_addr[ADDR_W-1:INDEX_W];
    assign wr_data  = (state == RD_MISS) ? mem_rdata : mem_wdata;
    // Fill on read-miss completion; write-through update only if the line hits.
    assign arr_we   = mem_ack && ((state == RD_MISS) || ((state == WR_MEM) && hit));

    // The cycle after a fill is the miss completing, not a new hit.
    assign hit_accept = (state == IDLE) && w_en && !r_en && hit && !fill_p1;

    cache_array #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (arr_we),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        stall = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (!w_en)      stall = 1'b1;
                    else if (!r_en) stall = !hit;
                end
                RD_MISS, WR_MEM: stall = 1'b1;
                default:         stall = 1'b0;
            endcase
        end
    end

    assign saida_cache = ((state == IDLE) && hit) ? line_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fill_p1    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_p1 <= 1'b0;
                    if (!w_en) begin
                        state     <= WR_MEM;
                        mem_addr  <= address;
                        mem_wdata <= data;
                        mem_wr    <= 1'b1;
                    end else if (!r_en && !hit) begin
                        state      <= RD_MISS;
                        mem_addr   <= address;
                        mem_rd     <= 1'b1;
                        miss_count <= sat_inc(miss_count);
                    end
                    if (hit_accept) hit_count <= sat_inc(hit_count);
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        mem_rd  <= 1'b0;
                        fill_p1 <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WR_MEM: begin
                    if (mem_ack) begin
                        mem_wr <= 1'b0;
                        state  <= WR_DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_dados.sv
module tb_cache_dados;

    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] data = '0;
    logic        r_en = 1'b1;
    logic        w_en = 1'b1;
    logic        stall;
    logic [31:0] saida_cache;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int checks = 0;
    int failures = 0;

    // Memory responder controls (written by the main sequence only)
    int lat = 3;
    bit ack_en = 1'b1;
    int force_req = 0;
    // Memory responder state (written by the responder only)
    int force_seen = 0;
    int busy = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [11:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] mem [int];

    cache_dados #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data        (data),
        .r_en        (r_en),
        .w_en        (w_en),
        .stall       (stall),
        .saida_cache (saida_cache),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mem_default(input logic [11:0] a);
        if (a == 12'h005) return 32'h0000ABCD;
        if (a == 12'h015) return 32'h55AA0015;
        return 32'hC0DE0000 | {20'h0, a};
    endfunction

    // Memory model: acks `lat` cycles after the strobe rises, on the negedge.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (force_req != force_seen) begin
            force_seen = force_req;
            mem_ack    = 1'b1;
            mem_rdata  = 32'hBAD0BAD0;
        end else if ((mem_rd || mem_wr) && ack_en) begin
            busy = busy + 1;
            if (busy >= lat) begin
                busy    = 0;
                mem_ack = 1'b1;
                if (mem_wr) begin
                    mem[int'(mem_addr)] = mem_wdata;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                    wr_cnt = wr_cnt + 1;
                end else begin
                    mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)]
                                                            : mem_default(mem_addr);
                    rd_cnt = rd_cnt + 1;
                end
            end
        end else begin
            busy = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue a request (entered just after a rising edge), wait for stall low,
    // capture saida_cache, let the accepting edge pass, then drop the enables.
    task automatic do_req(input bit rd, input bit wr, input logic [11:0] a,
                          input logic [31:0] d, output logic [31:0] q,
                          output int sc, output bit to);
        sc = 0;
        to = 1'b0;
        q  = '0;
        address = a;
        data    = d;
        r_en    = !rd;
        w_en    = !wr;
        for (int i = 0; i < MAXC; i++) begin
            @(negedge clk); #1;
            if (!stall) begin
                q = saida_cache;
                break;
            end
            sc = sc + 1;
            if (i == MAXC - 1) to = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_en = 1'b1;
        w_en = 1'b1;
    endtask

    typedef struct {
        bit          is_st;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] exp_q;
        int          exp_sc;
        int          exp_hit;
        int          exp_miss;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vt [10];
    logic [31:0] q;
    int sc;
    bit to;

    initial begin
        vt[0] = '{0, 12'h005, 32'h0,        32'h0000ABCD, 4, 0, 1, 1, 0};
        vt[1] = '{0, 12'h005, 32'h0,        32'h0000ABCD, 0, 1, 1, 1, 0};
        vt[2] = '{1, 12'h005, 32'h12345678, 32'h0,        4, 1, 1, 1, 1};
        vt[3] = '{0, 12'h005, 32'h0,        32'h12345678, 0, 2, 1, 1, 1};
        vt[4] = '{1, 12'h015, 32'hDEADBEEF, 32'h0,        4, 2, 1, 1, 2};
        vt[5] = '{0, 12'h005, 32'h0,        32'h12345678, 0, 3, 1, 1, 2};
        vt[6] = '{0, 12'h015, 32'h0,        32'hDEADBEEF, 4, 3, 2, 2, 2};
        vt[7] = '{0, 12'h005, 32'h0,        32'h12345678, 4, 3, 3, 3, 2};
        vt[8] = '{0, 12'h0A3, 32'h0,        32'hC0DE00A3, 4, 3, 4, 4, 2};
        vt[9] = '{0, 12'h0A3, 32'h0,        32'hC0DE00A3, 0, 4, 4, 4, 2};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",     stall,       0);
        chk("rst_mem_rd",    mem_rd,      0);
        chk("rst_mem_wr",    mem_wr,      0);
        chk("rst_mem_addr",  mem_addr,    0);
        chk("rst_mem_wdata", mem_wdata,   0);
        chk("rst_saida",     saida_cache, 0);
        chk("rst_hits",      hit_count,   0);
        chk("rst_misses",    miss_count,  0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed load/store vectors
        for (int i = 0; i < 10; i++) begin
            do_req(!vt[i].is_st, vt[i].is_st, vt[i].a, vt[i].d, q, sc, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_stall_cycles", i), sc, vt[i].exp_sc);
            if (!vt[i].is_st) begin
                chk($sformatf("v%0d_saida", i), q, vt[i].exp_q);
            end else begin
                chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vt[i].a);
                chk($sformatf("v%0d_wr_data", i), last_wr_data, vt[i].d);
            end
            chk($sformatf("v%0d_hits", i),   hit_count,  vt[i].exp_hit);
            chk($sformatf("v%0d_misses", i), miss_count, vt[i].exp_miss);
            chk($sformatf("v%0d_rd_txn", i), rd_cnt,     vt[i].exp_rd);
            chk($sformatf("v%0d_wr_txn", i), wr_cnt,     vt[i].exp_wr);
            chk($sformatf("v%0d_idle_strobes", i), {mem_rd, mem_wr}, 0);
        end

        // Both enables low: the store wins, no read issued; line 0xA3 hits and updates
        do_req(1'b1, 1'b1, 12'h0A3, 32'h11112222, q, sc, to);
        chk("dual_stall_cycles", sc, 4);
        chk("dual_rd_txn", rd_cnt, 4);
        chk("dual_wr_txn", wr_cnt, 3);
        chk("dual_wr_data", last_wr_data, 32'h11112222);
        do_req(1'b1, 1'b0, 12'h0A3, 32'h0, q, sc, to);
        chk("dual_reload_saida", q, 32'h11112222);
        chk("dual_reload_stall", sc, 0);
        chk("dual_reload_hits", hit_count, 5);

        // Reset during RD_MISS, then a late ack
        ack_en = 1'b0;
        address = 12'h077;
        r_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem_rd", mem_rd, 1);
        chk("abort_mem_addr", mem_addr, 12'h077);
        chk("abort_stall", stall, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_rst_stall", stall, 0);
        chk("abort_rst_mem_rd", mem_rd, 0);
        chk("abort_rst_mem_addr", mem_addr, 0);
        chk("abort_rst_saida", saida_cache, 0);
        chk("abort_rst_hits", hit_count, 0);
        chk("abort_rst_misses", miss_count, 0);
        r_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        force_req = force_req + 1;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_delivered", force_seen, force_req);
        chk("late_ack_mem_rd", mem_rd, 0);
        chk("late_ack_mem_wr", mem_wr, 0);
        chk("late_ack_stall", stall, 0);
        chk("late_ack_misses", miss_count, 0);
        ack_en = 1'b1;
        do_req(1'b1, 1'b0, 12'h0A3, 32'h0, q, sc, to);
        chk("post_rst_stall", sc, 4);
        chk("post_rst_saida", q, 32'h11112222);
        chk("post_rst_misses", miss_count, 1);
        chk("post_rst_hits", hit_count, 0);

        // Saturation of the 4-bit hit counter
        for (int i = 0; i < 15; i++) do_req(1'b1, 1'b0, 12'h0A3, 32'h0, q, sc, to);
        chk("sat_hits_15", hit_count, 15);
        do_req(1'b1, 1'b0, 12'h0A3, 32'h0, q, sc, to);
        chk("sat_hits_hold", hit_count, 15);
        chk("sat_saida", q, 32'h11112222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_dados.md
Name: cache_dados

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the multicycle MIPS core (Memory state) and the main data memory.
- Serves word loads/stores from the core and raises `stall` until each access completes.
- Produces the load word `saida_cache` consumed by the core's write-back path.
- Counts hits and misses for the board display.

Parameters:
- ADDR_W, 12, word address width from the core
- DATA_W, 32, data word width
- INDEX_W, 4, index bits; LINES = 2**INDEX_W, one word per line; tag width = ADDR_W-INDEX_W
- CNT_W, 16, width of the hit/miss counters

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address from core
- data  in  DATA_W  store data from core
- r_en  in  1  active-low load request, level-held by core until stall seen low
- w_en  in  1  active-low store request, level-held likewise
- stall  out  1  high while the current request is not complete
- saida_cache  out  DATA_W  load result, valid when r_en=0 and stall=0
- mem_addr  out  ADDR_W  main memory address
- mem_wdata  out  DATA_W  main memory write data
- mem_rd  out  1  active-high memory read strobe, held until mem_ack
- mem_wr  out  1  active-high memory write strobe, held until mem_ack
- mem_rdata  in  DATA_W  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse from memory, any latency >= 1
- hit_count  out  CNT_W  saturating load-hit counter
- miss_count  out  CNT_W  saturating load-miss counter

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all valid bits cleared.
  - stall=0; mem_rd=0; mem_wr=0; mem_addr=0; mem_wdata=0; saida_cache=0.
  - hit_count=0; miss_count=0.
  - Reset mid-operation aborts the access. Any mem_ack arriving afterwards is ignored.
- Address split: index = address[INDEX_W-1:0], tag = address[ADDR_W-1:INDEX_W].
- Hit = valid[index] && tag_array[index]==tag, evaluated combinationally in IDLE.
- Request priority: w_en=0 beats r_en=0 when both are low. Neither low means idle, stall=0.
- States: IDLE, RD_MISS, WR_MEM, WR_DONE.
- IDLE:
  - Load hit: stall=0 combinationally in the same cycle; saida_cache = data_array[index]. Latency 0 extra cycles. hit_count increments once per edge in which the hit is accepted; the core leaves Memory on that edge.
  - Load miss: stall=1 combinationally. On the next edge go to RD_MISS, latch mem_addr=address, set mem_rd=1, and increment miss_count.
  - Store: stall=1. On the next edge go to WR_MEM, latch mem_addr=address and mem_wdata=data, set mem_wr=1.
- RD_MISS:
  - stall=1, mem_rd held.
  - On the mem_ack edge: data_array[index]=mem_rdata, tag written, valid set, mem_rd=0, go to IDLE.
  - The following cycle is a hit, so stall falls and the access is not counted as a hit.
- WR_MEM:
  - stall=1, mem_wr held.
  - On the mem_ack edge: mem_wr=0. If the line is a hit, data_array[index]=data (write-through update); a miss leaves the line untouched (no allocate). Go to WR_DONE.
- WR_DONE:
  - stall=0 for exactly one cycle, then IDLE on the next edge.
  - The store is not reissued.
- The core must hold address/data/enables stable while stall=1. The cache captures memory-side values at request start and does not re-sample them.
- mem_ack outside RD_MISS/WR_MEM is ignored.
- Counters saturate at all-ones and never wrap.
- Only one memory transaction is outstanding at any time.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, RD_MISS=2'd1, WR_MEM=2'd2, WR_DONE=2'd3
  - default widths ADDR_W/DATA_W/INDEX_W
- Sub-module `cache_array`:
  - tag, data and valid storage
  - combinational read port, single synchronous write port, async valid clear

Test Plan:
- Reset, then load address 0x005 with memory holding 0x0000ABCD at latency 3:
  - stall high 4 cycles; one mem_rd pulse train
  - then stall=0, saida_cache=0x0000ABCD, miss_count=1, hit_count=0
- Repeat load of 0x005:
  - stall=0 same cycle, no mem_rd, hit_count=1
- Store 0x12345678 to 0x005 (hit):
  - mem_wr with mem_addr=0x005, mem_wdata=0x12345678
  - WR_DONE gives one stall-low cycle
  - next load of 0x005 hits and returns 0x12345678
- Store to 0x015 (same index, different tag, miss):
  - memory written; line 5 still holds tag 0 data
  - load 0x015 then misses, and subsequently evicts line 5
- r_en=0 and w_en=0 together:
  - a write transaction is issued, with no read
- rst pulse low while in RD_MISS, then late mem_ack:
  - outputs back to reset values; ack ignored
  - load of the previously filled address misses
